// File: rtl/sbox_layer_ctrl.sv
// ASCON substitution-layer sequencer.
// Loads a 320-bit state and runs every bit-column through a bank of NB_SBOX
// 5-bit S-boxes, NB_SBOX columns per clock, then pulses done for one cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i; state register holds last result
// RUN    | substituting column group cnt; busy_o high
// DONE   | state_o holds the final result; done_o high for one cycle

// 5-bit ASCON S-box, bit 4 = x0 ... bit 0 = x4.
module sbox (
  input  logic [4:0] sbox_i,
  output logic [4:0] sbox_o
);

  // Substitution table lookup
  always_comb begin
    sbox_o = 5'h00;
    case (sbox_i)
      5'h00: sbox_o = 5'h04;  5'h01: sbox_o = 5'h0b;
      5'h02: sbox_o = 5'h1f;  5'h03: sbox_o = 5'h14;
      5'h04: sbox_o = 5'h1a;  5'h05: sbox_o = 5'h15;
      5'h06: sbox_o = 5'h09;  5'h07: sbox_o = 5'h02;
      5'h08: sbox_o = 5'h1b;  5'h09: sbox_o = 5'h05;
      5'h0a: sbox_o = 5'h08;  5'h0b: sbox_o = 5'h12;
      5'h0c: sbox_o = 5'h1d;  5'h0d: sbox_o = 5'h03;
      5'h0e: sbox_o = 5'h06;  5'h0f: sbox_o = 5'h1c;
      5'h10: sbox_o = 5'h1e;  5'h11: sbox_o = 5'h13;
      5'h12: sbox_o = 5'h07;  5'h13: sbox_o = 5'h0e;
      5'h14: sbox_o = 5'h00;  5'h15: sbox_o = 5'h0d;
      5'h16: sbox_o = 5'h11;  5'h17: sbox_o = 5'h18;
      5'h18: sbox_o = 5'h10;  5'h19: sbox_o = 5'h0c;
      5'h1a: sbox_o = 5'h01;  5'h1b: sbox_o = 5'h19;
      5'h1c: sbox_o = 5'h16;  5'h1d: sbox_o = 5'h0a;
      5'h1e: sbox_o = 5'h0f;  5'h1f: sbox_o = 5'h17;
      default: sbox_o = 5'h00;
    endcase
  end

endmodule

module sbox_layer_ctrl #(
  parameter int NB_SBOX = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int N  = 64 / NB_SBOX;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [8:0]    NB9      = 9'(NB_SBOX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (NB_SBOX != 1 && NB_SBOX != 2 && NB_SBOX != 4 && NB_SBOX != 8 &&
      NB_SBOX != 16 && NB_SBOX != 32 && NB_SBOX != 64) begin : g_bad_param
    $error("sbox_layer_ctrl: NB_SBOX must be a power of two from 1 to 64");
  end

  logic [1:0]         r_fsm;
  logic [CW-1:0]      r_cnt;
  logic [319:0]       r_state;

  logic [8:0]         w_base;
  logic [NB_SBOX-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [NB_SBOX-1:0] w_y0, w_y1, w_y2, w_y3, w_y4;
  logic               w_accept;

  assign w_accept = start_i && (r_fsm == S_IDLE || r_fsm == S_DONE);

  // First column of the group handled this cycle
  always_comb begin
    w_base = 9'(r_cnt) * NB9;
  end

  // Gather the current column group from each of the five words
  always_comb begin
    w_x0 = r_state[w_base + 9'd256 +: NB_SBOX];
    w_x1 = r_state[w_base + 9'd192 +: NB_SBOX];
    w_x2 = r_state[w_base + 9'd128 +: NB_SBOX];
    w_x3 = r_state[w_base + 9'd64  +: NB_SBOX];
    w_x4 = r_state[w_base          +: NB_SBOX];
  end

  for (genvar g = 0; g < NB_SBOX; g++) begin : g_bank
    logic [4:0] w_in;
    logic [4:0] w_out;

    assign w_in = {w_x0[g], w_x1[g], w_x2[g], w_x3[g], w_x4[g]};

    sbox u_sbox (
      .sbox_i (w_in),
      .sbox_o (w_out)
    );

    assign w_y0[g] = w_out[4];
    assign w_y1[g] = w_out[3];
    assign w_y2[g] = w_out[2];
    assign w_y3[g] = w_out[1];
    assign w_y4[g] = w_out[0];
  end

  // Sequencer state and column-group counter
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fsm <= S_IDLE;
      r_cnt <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_fsm <= S_RUN;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_fsm <= S_DONE;
          end
        end
        S_DONE: begin
          r_cnt <= '0;
          r_fsm <= w_accept ? S_RUN : S_IDLE;
        end
        default: begin
          r_fsm <= S_IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // State register: load on an accepted start, write back one group per RUN cycle
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= '0;
    end else if (w_accept) begin
      r_state <= state_i;
    end else if (r_fsm == S_RUN) begin
      r_state[w_base + 9'd256 +: NB_SBOX] <= w_y0;
      r_state[w_base + 9'd192 +: NB_SBOX] <= w_y1;
      r_state[w_base + 9'd128 +: NB_SBOX] <= w_y2;
      r_state[w_base + 9'd64  +: NB_SBOX] <= w_y3;
      r_state[w_base          +: NB_SBOX] <= w_y4;
    end
  end

  assign state_o = r_state;
  assign busy_o  = (r_fsm == S_RUN);
  assign done_o  = (r_fsm == S_DONE);

endmodule

// File: doc/sbox_layer_ctrl.md
# sbox_layer_ctrl

Sequencer for the ASCON substitution layer. It loads a 320-bit permutation state (x0..x4, 64 bits each) and pushes all 64 bit-columns through a bank of `NB_SBOX` instances of the existing 5-bit `sbox` (`sbox_i`/`sbox_o`), `NB_SBOX` columns per clock. It then returns the substituted state with a one-cycle done pulse. It sits between the round controller and the linear diffusion layer, and lets area-constrained builds time-share a small number of S-boxes.

## Interface
- `NB_SBOX`, default 8: S-box instances, i.e. columns processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64; any other value is an elaboration error.
- `clock_i` input, 1 bit: single clock. All state changes on the rising edge.
- `reset_i` input, 1 bit: reset, asynchronous and active-high.
- `start_i` input, 1 bit: request to load `state_i` and run one substitution layer.
- `state_i` input, 320 bits: state to substitute. x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0].
- `state_o` output, 320 bits: state register contents, with the same packing as `state_i`.
- `busy_o` output, 1 bit: high while a load has been accepted and substitution is in progress.
- `done_o` output, 1 bit: one-cycle pulse when `state_o` holds the finished result.

## Operation
- Column i (i = 0..63) forms the S-box input {x0[i], x1[i], x2[i], x3[i], x4[i]}, with x0 as the MSB (bit 4) and x4 as the LSB (bit 0). The S-box output bits are written back to the same column in the same order.
- `N = 64 / NB_SBOX` processing cycles per layer. A counter of width `max(1, log2(N))` wraps from N-1 to 0.
- FSM states:
  - IDLE: waiting. `start_i` = 1 loads `state_i` into the state register, clears the counter and moves to RUN.
  - RUN: each cycle substitutes columns `[cnt*NB_SBOX +: NB_SBOX]` of all five words and increments `cnt`. At `cnt == N-1` it moves to DONE.
  - DONE: `done_o` = 1 for exactly this one cycle. With `start_i` = 1 it loads and moves to RUN (back-to-back layers); otherwise it moves to IDLE.
- `start_i` in RUN is ignored: no reload and no queuing.
- `state_i` is sampled only on the accepting edge. Later changes to it do not affect a run in progress.
- `state_o` reflects the register in every state. It holds partially substituted data during RUN and the final result from DONE until the next accepted start.
- Implementations may use a column-rotating register instead of index muxing, provided the observable `state_o` in DONE/IDLE and the cycle timing are identical.
- Reset values: FSM = IDLE, counter = 0, state register = 320'h0, `busy_o` = 0, `done_o` = 0.
- Reset asserted mid-RUN aborts immediately to the reset values. There is no done pulse and partial data is discarded.

## Timing
- Edge E0: `start_i` = 1 is sampled in IDLE or DONE, and the state register loads.
- `busy_o` is high from after E0 through the last RUN cycle. It is low in DONE and IDLE.
- RUN occupies edges E1..EN, with one column group updated per edge.
- `done_o` is high during the cycle following EN, so the latency from the accepting edge to `done_o` is N cycles:
  - 8 for `NB_SBOX` = 8.
  - 64 for `NB_SBOX` = 1.
  - 1 for `NB_SBOX` = 64.
- Back-to-back throughput is one layer every N+1 cycles (start accepted in DONE).
- `done_o` and `busy_o` are registered outputs (FSM state decode); there is no combinational path from `start_i`.

## Test plan
- All-zero state: every column maps 0x00 -> 0x04, so with `NB_SBOX` = 8, `done_o` rises 8 cycles after start with x2 = 64'hFFFF_FFFF_FFFF_FFFF and x0, x1, x3, x4 = 0.
- All-ones state: every column maps 0x1F -> 0x17, giving x0, x2, x3, x4 = all ones and x1 = 0.
- Column walk: set column i to value i mod 32 for i = 0..63 and check each output column against the S-box table (0x00->0x04, 0x01->0x0B, ..., 0x1F->0x17). Repeat for `NB_SBOX` = 1, 8 and 64 and check latencies of 64, 8 and 1 cycles.
- Start in RUN: pulse `start_i` with a different `state_i` at cycle 3 of a run. Required: no reload, done at the original cycle, result computed from the first state.
- Back-to-back: hold `start_i` = 1 continuously. Required: `done_o` pulses every N+1 cycles, with each result matching its own loaded state.
- Reset at cycle 4 of RUN: outputs go to zero asynchronously and no `done_o` pulse occurs. A new start after release completes normally.
